// File: rtl/host_wire_bridge_pkg.sv
// Shared defaults and types for the host toggle-handshake to decoupled-stream bridge.
package host_wire_bridge_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 32;

  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous valid/ready FIFO; full/empty come from an extra pointer MSB, no push bypass on full.
module bridge_fifo
  import host_wire_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign level     = wr_ptr - rd_ptr;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/host_wire_bridge.sv
// Bridges a host-side toggle handshake to decoupled emulator streams in both directions.
module host_wire_bridge
  import host_wire_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    host_req_tog,
  input  logic [DATA_W-1:0]       host_req_data,
  output logic                    host_req_ack_tog,
  output logic                    host_rsp_tog,
  output logic [DATA_W-1:0]       host_rsp_data,
  input  logic                    host_rsp_ack_tog,
  output logic                    enq_valid,
  input  logic                    enq_ready,
  output logic [DATA_W-1:0]       enq_bits,
  input  logic                    deq_valid,
  output logic                    deq_ready,
  input  logic [DATA_W-1:0]       deq_bits,
  output logic [CNT_W-1:0]        req_count,
  output logic [CNT_W-1:0]        rsp_count,
  output logic [$clog2(DEPTH):0]  req_level,
  output logic [$clog2(DEPTH):0]  rsp_level
);

  logic              req_pending;
  logic              req_in_ready;
  logic              req_accept;
  logic              rsp_in_ready;
  logic              rsp_out_valid;
  logic [DATA_W-1:0] rsp_out_data;
  logic              rsp_idle;
  logic              rsp_present;

  assign req_pending = (host_req_tog != host_req_ack_tog);
  assign req_accept  = req_pending && req_in_ready;
  assign rsp_idle    = (host_rsp_tog == host_rsp_ack_tog);
  assign rsp_present = rsp_idle && rsp_out_valid;
  // Hold off the emulator for the whole reset window, not just until pointers clear.
  assign deq_ready   = rsp_in_ready && !reset;

  bridge_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clock    (clock),
    .reset    (reset),
    .in_valid (req_pending),
    .in_ready (req_in_ready),
    .in_data  (host_req_data),
    .out_valid(enq_valid),
    .out_ready(enq_ready),
    .out_data (enq_bits),
    .level    (req_level)
  );

  bridge_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .in_valid (deq_valid),
    .in_ready (rsp_in_ready),
    .in_data  (deq_bits),
    .out_valid(rsp_out_valid),
    .out_ready(rsp_idle),
    .out_data (rsp_out_data),
    .level    (rsp_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host_req_ack_tog <= 1'b0;
      req_count        <= '0;
    end else if (req_accept) begin
      host_req_ack_tog <= ~host_req_ack_tog;
      req_count        <= req_count + CNT_W'(1);
    end
  end

  // The presented word stays frozen until the host echoes the toggle back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host_rsp_tog  <= 1'b0;
      host_rsp_data <= '0;
      rsp_count     <= '0;
    end else if (rsp_present) begin
      host_rsp_tog  <= ~host_rsp_tog;
      host_rsp_data <= rsp_out_data;
      rsp_count     <= rsp_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_host_wire_bridge.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor pops and compares them.
module tb_host_wire_bridge;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic              host_req_tog;
  logic [DATA_W-1:0] host_req_data;
  logic              host_req_ack_tog;
  logic              host_rsp_tog;
  logic [DATA_W-1:0] host_rsp_data;
  logic              host_rsp_ack_tog;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [CNT_W-1:0]  req_count;
  logic [CNT_W-1:0]  rsp_count;
  logic [LW-1:0]     req_level;
  logic [LW-1:0]     rsp_level;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_enq [$];
  logic [DATA_W-1:0] exp_rsp [$];
  logic              last_rsp_tog = 1'b0;

  host_wire_bridge #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .host_req_tog    (host_req_tog),
    .host_req_data   (host_req_data),
    .host_req_ack_tog(host_req_ack_tog),
    .host_rsp_tog    (host_rsp_tog),
    .host_rsp_data   (host_rsp_data),
    .host_rsp_ack_tog(host_rsp_ack_tog),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_bits        (enq_bits),
    .deq_valid       (deq_valid),
    .deq_ready       (deq_ready),
    .deq_bits        (deq_bits),
    .req_count       (req_count),
    .rsp_count       (rsp_count),
    .req_level       (req_level),
    .rsp_level       (rsp_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Flip the request toggle with a new word and expect it on the enq stream later.
  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    host_req_data = d;
    host_req_tog  = ~host_req_tog;
    exp_enq.push_back(d);
    tick();
  endtask

  task automatic drainRsp();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 40) begin
      host_rsp_ack_tog = host_rsp_tog;
      tick();
      n++;
    end
    host_rsp_ack_tog = host_rsp_tog;
    checkOutput("rsp_drain", 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic drainEnq();
    int n;
    n = 0;
    while (exp_enq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("enq_drain", 32'(exp_enq.size()), 32'd0);
  endtask

  // Monitor: every enq handshake and every new presentation is matched against the queues.
  always @(negedge clock) begin
    if (reset) begin
      last_rsp_tog = 1'b0;
    end else begin
      if (enq_valid && enq_ready) begin
        if (exp_enq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL enq_unexpected: got 0x%0h expected no word", enq_bits);
        end else begin
          checkOutput("enq_bits", 32'(enq_bits), 32'(exp_enq.pop_front()));
        end
      end
      if (host_rsp_tog != last_rsp_tog) begin
        last_rsp_tog = host_rsp_tog;
        if (exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rsp_unexpected: got 0x%0h expected no word", host_rsp_data);
        end else begin
          checkOutput("rsp_data", 32'(host_rsp_data), 32'(exp_rsp.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    host_req_tog = 1'b0;
    host_req_data = '0;
    host_rsp_ack_tog = 1'b0;
    enq_ready = 1'b0;
    deq_valid = 1'b0;
    deq_bits = '0;
    tick();
    tick();

    checkOutput("rst_enq_valid", 32'(enq_valid), 32'd0);
    checkOutput("rst_deq_ready", 32'(deq_ready), 32'd0);
    checkOutput("rst_ack_tog", 32'(host_req_ack_tog), 32'd0);
    checkOutput("rst_rsp_tog", 32'(host_rsp_tog), 32'd0);
    checkOutput("rst_rsp_data", 32'(host_rsp_data), 32'd0);
    checkOutput("rst_counts", {req_count, rsp_count}, 32'd0);
    checkOutput("rst_levels", {req_level, rsp_level}, 32'd0);

    reset = 1'b0;
    #1;
    checkOutput("deq_ready_after_rst", 32'(deq_ready), 32'd1);

    // Single request
    enq_ready = 1'b1;
    applyStimulus(16'h1234);
    checkOutput("single_ack", 32'(host_req_ack_tog), 32'd1);
    checkOutput("single_count", 32'(req_count), 32'd1);
    checkOutput("single_enq_valid", 32'(enq_valid), 32'd1);
    checkOutput("single_enq_bits", 32'(enq_bits), 32'h1234);
    tick();
    checkOutput("single_enq_valid_drop", 32'(enq_valid), 32'd0);

    // Backpressure: four fill the FIFO, the fifth stalls
    enq_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(DATA_W'(i));
      checkOutput("bp_ack", 32'(host_req_ack_tog == host_req_tog), 32'd1);
    end
    applyStimulus(16'h0005);
    tick();
    tick();
    checkOutput("bp_stall_ack", 32'(host_req_ack_tog), 32'd1);
    checkOutput("bp_level_full", 32'(req_level), 32'd4);
    enq_ready = 1'b1;
    tick();
    checkOutput("bp_no_bypass_ack", 32'(host_req_ack_tog), 32'd1);
    checkOutput("bp_level_after_pop", 32'(req_level), 32'd3);
    tick();
    checkOutput("bp_fifth_ack", 32'(host_req_ack_tog), 32'd0);
    checkOutput("bp_level_push_pop", 32'(req_level), 32'd3);
    drainEnq();
    checkOutput("bp_count", 32'(req_count), 32'd6);

    // Response presentation
    deq_valid = 1'b1;
    deq_bits = 16'hAAAA;
    exp_rsp.push_back(16'hAAAA);
    tick();
    deq_bits = 16'hBBBB;
    exp_rsp.push_back(16'hBBBB);
    tick();
    deq_valid = 1'b0;
    checkOutput("rsp_first_data", 32'(host_rsp_data), 32'hAAAA);
    checkOutput("rsp_first_tog", 32'(host_rsp_tog), 32'd1);
    checkOutput("rsp_queued_level", 32'(rsp_level), 32'd1);
    tick();
    checkOutput("rsp_frozen", 32'(host_rsp_data), 32'hAAAA);
    host_rsp_ack_tog = 1'b1;
    tick();
    checkOutput("rsp_second_data", 32'(host_rsp_data), 32'hBBBB);
    checkOutput("rsp_second_tog", 32'(host_rsp_tog), 32'd0);
    checkOutput("rsp_count_2", 32'(rsp_count), 32'd2);
    host_rsp_ack_tog = 1'b0;
    tick();

    // Response full: host holds off, six beats offered, five accepted
    deq_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      deq_bits = DATA_W'(16'h0100 + i);
      checkOutput("rsp_full_deq_ready", 32'(deq_ready), (i < 5) ? 32'd1 : 32'd0);
      if (i < 5) exp_rsp.push_back(DATA_W'(16'h0100 + i));
      tick();
    end
    deq_valid = 1'b0;
    checkOutput("rsp_full_level", 32'(rsp_level), 32'd4);
    checkOutput("rsp_full_data", 32'(host_rsp_data), 32'h0100);
    drainRsp();
    tick();
    checkOutput("rsp_count_7", 32'(rsp_count), 32'd7);

    // Reset mid-operation
    deq_valid = 1'b1;
    deq_bits = 16'h5A5A;
    exp_rsp.push_back(16'h5A5A);
    tick();
    deq_valid = 1'b0;
    tick();
    enq_ready = 1'b0;
    applyStimulus(16'h0A01);
    applyStimulus(16'h0A02);
    applyStimulus(16'h0A03);
    checkOutput("pre_rst_level", 32'(req_level), 32'd3);
    reset = 1'b1;
    #1;
    exp_enq.delete();
    checkOutput("mid_rst_enq_valid", 32'(enq_valid), 32'd0);
    checkOutput("mid_rst_deq_ready", 32'(deq_ready), 32'd0);
    checkOutput("mid_rst_levels", {req_level, rsp_level}, 32'd0);
    checkOutput("mid_rst_counts", {req_count, rsp_count}, 32'd0);
    checkOutput("mid_rst_toggles", {host_req_ack_tog, host_rsp_tog}, 32'd0);
    checkOutput("mid_rst_rsp_data", 32'(host_rsp_data), 32'd0);
    checkOutput("mid_rst_rsp_seen", 32'(exp_rsp.size()), 32'd0);
    host_req_tog = 1'b0;
    host_rsp_ack_tog = 1'b0;
    exp_rsp.delete();
    tick();
    reset = 1'b0;

    // Counter wrap with a 4-bit counter; first edge after reset is live
    enq_ready = 1'b1;
    applyStimulus(16'h0000);
    checkOutput("post_rst_ack", 32'(host_req_ack_tog), 32'd1);
    for (int i = 1; i < 17; i++) begin
      applyStimulus(DATA_W'(16'h0C00 + i));
      if (i == 8) checkOutput("steady_level", 32'(req_level), 32'd1);
    end
    checkOutput("wrap_count", 32'(req_count), 32'd1);
    drainEnq();
    checkOutput("wrap_level_empty", 32'(req_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
